// File: rtl/peregrine_dram1_dma_pkg.sv
// peregrine_dram1_dma_pkg: shared types and default sizes for the DRAM1 burst engine
package peregrine_dram1_dma_pkg;
    localparam int DEF_AWIDTH    = 16;
    localparam int DEF_LENW      = 4;
    localparam int DEF_RDQ_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } rd_entry_t;
endpackage

// File: rtl/peregrine_dram1_dma_if.sv
// peregrine_dram1_dma_if: command, write, read and DRAM1 port signals of the burst engine
interface peregrine_dram1_dma_if
    import peregrine_dram1_dma_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int LENW   = DEF_LENW
);
    logic              CmdValid;
    logic              CmdReady;
    logic              CmdWrite;
    logic [AWIDTH-1:0] CmdAddr;
    logic [LENW-1:0]   CmdLen;
    logic              WrValid;
    logic              WrReady;
    logic [31:0]       WrData;
    logic [3:0]        WrByteEn;
    logic              RdValid;
    logic              RdReady;
    logic [31:0]       RdData;
    logic              RdLast;
    logic              Busy;
    logic [AWIDTH-1:0] DRam1Addr0;
    logic              DRam1En0;
    logic              DRam1Wr0;
    logic [3:0]        DRam1ByteEn0;
    logic [31:0]       DRam1WrData0;
    logic [31:0]       DRam1Data0;

    modport slave (
        input  CmdValid, CmdWrite, CmdAddr, CmdLen, WrValid, WrData, WrByteEn, RdReady, DRam1Data0,
        output CmdReady, WrReady, RdValid, RdData, RdLast, Busy,
               DRam1Addr0, DRam1En0, DRam1Wr0, DRam1ByteEn0, DRam1WrData0
    );

    modport master (
        output CmdValid, CmdWrite, CmdAddr, CmdLen, WrValid, WrData, WrByteEn, RdReady, DRam1Data0,
        input  CmdReady, WrReady, RdValid, RdData, RdLast, Busy,
               DRam1Addr0, DRam1En0, DRam1Wr0, DRam1ByteEn0, DRam1WrData0
    );
endinterface

// File: rtl/peregrine_dram1_dma_rdfifo.sv
// peregrine_dram1_dma_rdfifo: read response FIFO, outputs straight from storage flops
module peregrine_dram1_dma_rdfifo
    import peregrine_dram1_dma_pkg::*;
#(
    parameter int DEPTH = DEF_RDQ_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic      CLK,
    input  logic      Reset,
    input  logic      i_push,
    input  rd_entry_t i_data,
    input  logic      i_pop,
    output rd_entry_t o_data,
    output logic [AW:0] o_count
);
    rd_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((int'(r_count) != DEPTH) || w_pop);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    // storage, pointers and occupancy; cleared so outputs read zero after reset
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/peregrine_dram1_dma.sv
// peregrine_dram1_dma: word-burst read/write engine owning the DRAM1 single port
module peregrine_dram1_dma
    import peregrine_dram1_dma_pkg::*;
#(
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int LENW      = DEF_LENW,
    parameter int RDQ_DEPTH = DEF_RDQ_DEPTH,
    localparam int CW       = $clog2(RDQ_DEPTH) + 1
) (
    input logic                  CLK,
    input logic                  Reset,
    peregrine_dram1_dma_if.slave bus
);
    state_t            r_state;
    state_t            w_next;
    logic [AWIDTH-1:0] r_addr;
    logic [LENW-1:0]   r_len;
    logic [LENW:0]     r_cnt;
    logic              r_mem_en;
    logic              r_mem_wr;
    logic [AWIDTH-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_last1;
    logic              r_pend2;
    logic              r_last2;
    logic              w_cmd_fire;
    logic              w_wr_fire;
    logic              w_issue;
    logic              w_last_beat;
    logic              w_pop;
    logic [1:0]        w_inflight;
    logic [CW-1:0]     w_count;
    rd_entry_t         w_head;

    // reads on the port (stage 1) plus data currently on DRam1Data0 (stage 2)
    assign w_inflight  = {1'b0, r_mem_en & ~r_mem_wr} + {1'b0, r_pend2};
    assign w_cmd_fire  = (r_state == IDLE) && bus.CmdValid;
    assign w_wr_fire   = (r_state == WRITE) && bus.WrValid;
    // only issue when every outstanding read is guaranteed a FIFO slot
    assign w_issue     = (r_state == READ) && (int'(w_count) + int'(w_inflight) < RDQ_DEPTH);
    assign w_last_beat = r_cnt == {1'b0, r_len};
    assign w_pop       = bus.RdReady && (w_count != '0);

    assign bus.CmdReady     = r_state == IDLE;
    assign bus.WrReady      = r_state == WRITE;
    assign bus.Busy         = r_state != IDLE;
    assign bus.RdValid      = w_count != '0;
    assign bus.RdData       = w_head.data;
    assign bus.RdLast       = w_head.last;
    assign bus.DRam1Addr0   = r_mem_addr;
    assign bus.DRam1En0     = r_mem_en;
    assign bus.DRam1Wr0     = r_mem_wr;
    assign bus.DRam1ByteEn0 = r_mem_be;
    assign bus.DRam1WrData0 = r_mem_wdata;

    peregrine_dram1_dma_rdfifo #(.DEPTH(RDQ_DEPTH)) u_rdfifo (
        .CLK     (CLK),
        .Reset   (Reset),
        .i_push  (r_pend2),
        .i_data  ('{data: bus.DRam1Data0, last: r_last2}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    // state register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next state; DRAIN leaves as soon as the final beat is being consumed
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.CmdValid) w_next = bus.CmdWrite ? WRITE : READ;
            WRITE:   if (w_wr_fire && w_last_beat) w_next = IDLE;
            READ:    if (w_issue && w_last_beat) w_next = DRAIN;
            DRAIN:   if (w_inflight == 2'd0 && (w_count == '0 || (int'(w_count) == 1 && w_pop))) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // burst bookkeeping, registered DRAM1 port and the read-latency pipeline
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_last1     <= 1'b0;
            r_pend2     <= 1'b0;
            r_last2     <= 1'b0;
        end else begin
            r_mem_en <= w_wr_fire | w_issue;
            r_mem_wr <= w_wr_fire;
            r_last1  <= w_issue & w_last_beat;
            r_pend2  <= r_mem_en & ~r_mem_wr;
            r_last2  <= r_last1;
            if (w_cmd_fire) begin
                r_addr <= bus.CmdAddr;
                r_len  <= bus.CmdLen;
                r_cnt  <= '0;
            end
            if (w_wr_fire | w_issue) begin
                r_mem_addr <= r_addr;
                r_addr     <= r_addr + 1'b1;
                r_cnt      <= r_cnt + 1'b1;
            end
            if (w_wr_fire) begin
                r_mem_be    <= bus.WrByteEn;
                r_mem_wdata <= bus.WrData;
            end
        end
    end
endmodule

// File: doc/peregrine_dram1_dma.md
# peregrine_dram1_dma

Burst access engine that sits directly upstream of the DRAM1 local-memory macro and owns its single read/write port. Accepts word-burst read/write commands over valid/ready handshakes, issues one sequential word access per cycle to DRAM1, and returns read data through a 4-entry response FIFO. The FIFO absorbs the memory's 1-cycle read latency under consumer backpressure. Used by testbench/cosim DMA and by the preload path as an alternative to backdoor pokes.

## Interface
- AWIDTH, 16, word-address width (64K words = 256 KB)
- LENW, 4, burst length field width; bursts are 1..2^LENW words
- RDQ_DEPTH, 4, read response FIFO depth (power of two, ≥ 3)

Clocking and reset (already decided): one clock `CLK`; reset `Reset` is asynchronous and active-high.

- CLK  in  1  clock
- Reset  in  1  async active-high reset
- CmdValid  in  1  command valid
- CmdReady  out  1  command accepted when both high
- CmdWrite  in  1  1 = write burst, 0 = read burst
- CmdAddr  in  AWIDTH  starting word address
- CmdLen  in  LENW  beats minus one
- WrValid  in  1  write beat valid
- WrReady  out  1  write beat accepted when both high
- WrData  in  32  write beat data
- WrByteEn  in  4  write beat byte lanes
- RdValid  out  1  read beat valid
- RdReady  in  1  read beat consumed when both high
- RdData  out  32  read beat data
- RdLast  out  1  final beat of the current read burst
- Busy  out  1  state ≠ IDLE
- DRam1Addr0  out  AWIDTH  memory word address (registered)
- DRam1En0  out  1  memory enable (registered)
- DRam1Wr0  out  1  memory write (registered)
- DRam1ByteEn0  out  4  memory byte enables (registered)
- DRam1WrData0  out  32  memory write data (registered)
- DRam1Data0  in  32  memory read data, valid the cycle after an enabled read

## Operation
- States:
  - IDLE: CmdReady = 1. On accept, latch addr/len/dir. Go to WRITE or READ.
  - WRITE: WrReady = 1. Each accepted beat registers En=1, Wr=1, addr, ByteEn, data, then increments addr. On the last beat, go to IDLE.
  - READ: issue a read (En=1, Wr=0) in each cycle where fifo_count + inflight < RDQ_DEPTH. On the last issue, go to DRAIN.
  - DRAIN: wait until inflight = 0 and FIFO empty, then go to IDLE.
- No issue in a cycle leaves DRam1En0 = 0 and DRam1Wr0 = 0. Addr, ByteEn and data hold their last values.
- inflight (0..2) counts reads issued but not yet captured. The FIFO captures DRam1Data0 two edges after the issue edge.
- Address increments modulo 2^AWIDTH; a burst wraps from 0xFFFF to 0x0000.
- A beat counter of LENW+1 bits compares against CmdLen. RdLast is carried per FIFO entry.
- Ordering: a read issued after a write burst always observes the written data. Single port, in-order issue.
- WrValid outside WRITE is ignored. RdReady with RdValid = 0 has no effect.
- Reset, including mid-burst: FSM → IDLE; FIFO, inflight and counters cleared. All outputs go to 0 except CmdReady, which is 1 after reset since the FSM is in IDLE. Memory contents are untouched.

## Timing
- Cmd accept at edge E0 → first DRAM1 access registered at E1.
- Write beat accepted at edge Ek → array updated at Ek+1.
- Read: issue at E1, memory samples at E2, FIFO captures at E3. RdValid rises after E3, i.e. 3 cycles after command accept.
- With RdReady held high, throughput is 1 word/cycle.
- Burst of N reads with no backpressure: RdValid asserted for N consecutive cycles. CmdReady returns high the cycle after the last beat is consumed.
- Write burst of N beats with WrValid high: N cycles in WRITE, CmdReady high the cycle after the last beat.
- RdData/RdValid/RdLast come from FIFO flops, with no combinational path from RdReady.

## Structure
- Package `peregrine_dram1_dma_pkg`:
  - state enum {IDLE, WRITE, READ, DRAIN}
  - default RDQ_DEPTH, AWIDTH, LENW localparams
  - read response entry struct {data[31:0], last}
- Sub-module `peregrine_dram1_dma_rdfifo`: synchronous FIFO of RDQ_DEPTH entries with count output, async reset, simultaneous push/pop allowed at full.

## Test plan
- Write burst addr 0x0010, len 3, data 0xA0..0xA3, ByteEn 0xF → array[0x10..0x13] = 0xA0..0xA3; CmdReady high the cycle after the 4th beat.
- Read back the same burst with RdReady = 1 → RdValid 3 cycles after accept, data 0xA0..0xA3 on 4 consecutive cycles, RdLast only on 0xA3.
- Read len 15 with RdReady toggling 1-0-0-1 → all 16 words in order, no loss or duplication, fifo_count + inflight never exceeds 4.
- Write addr 0xFFFE, len 3 → words land at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Byte-lane write ByteEn 0x5, data 0x11223344 over 0xFFFFFFFF → word reads 0xFF22FF44.
- Assert Reset mid-read after 2 beats → all outputs 0 except CmdReady = 1 after reset, no further RdValid; a new read command afterwards completes normally.
